// File: rtl/clk_step_ctrl.sv
// CPU clock-enable sequencer: programmable divider, reset hold, run/halt/single-step
// control and a cycle-count breakpoint.
module clk_step_ctrl #(
    parameter int unsigned DIV_W        = 8,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned RST_CYCLES   = 4,
    parameter bit          START_HALTED = 1'b0
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [DIV_W-1:0] DIV,
    input  logic             RUN_REQ,
    input  logic             HALT_REQ,
    input  logic             STEP_REQ,
    input  logic             BRK_EN,
    input  logic [CNT_W-1:0] BRK_VAL,
    output logic             CPU_EN,
    output logic             CPU_RST_N,
    output logic [CNT_W-1:0] CYCLE_CNT,
    output logic             HALTED,
    output logic [1:0]       STATE
);

    localparam int unsigned        HOLD_N    = (RST_CYCLES == 0) ? 1 : RST_CYCLES;
    localparam int unsigned        HOLD_W    = $clog2(HOLD_N + 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_N - 1);

    typedef enum logic [1:0] {
        ST_RST_HOLD = 2'b00,
        ST_RUN      = 2'b01,
        ST_HALT     = 2'b10,
        ST_STEP     = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               cpu_rst_n_q, cpu_rst_n_d;
    logic               halted_q, halted_d;
    logic               tick;
    logic               cpu_en;

    always_comb begin
        // >= rather than == so a DIV drop below the running count ticks at once
        tick        = (div_cnt_q >= DIV);
        div_cnt_d   = tick ? '0 : div_cnt_q + 1'b1;
        cnt_inc     = cnt_q + 1'b1;
        state_d     = state_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        cpu_en      = 1'b0;

        case (state_q)
            ST_RST_HOLD: begin
                cpu_en = tick;
                if (tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        state_d = START_HALTED ? ST_HALT : ST_RUN;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (HALT_REQ) begin
                    state_d = ST_HALT;
                end else if (tick) begin
                    cpu_en = 1'b1;
                    cnt_d  = cnt_inc;
                    if (BRK_EN && (cnt_inc == BRK_VAL)) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_HALT: begin
                if (RUN_REQ) begin
                    state_d = ST_RUN;
                end else if (STEP_REQ) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (tick) begin
                    cpu_en  = 1'b1;
                    cnt_d   = cnt_inc;
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_RST_HOLD;
        endcase

        cpu_rst_n_d = (state_d != ST_RST_HOLD);
        halted_d    = (state_d == ST_HALT);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_RST_HOLD;
            div_cnt_q   <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            cpu_rst_n_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            halted_q    <= halted_d;
        end
    end

    // The enable is a same-cycle decode of the tick; gating with RST_N makes it
    // drop immediately on reset assertion like the registered outputs.
    assign CPU_EN    = cpu_en & RST_N;
    assign CPU_RST_N = cpu_rst_n_q;
    assign CYCLE_CNT = cnt_q;
    assign HALTED    = halted_q;
    assign STATE     = state_q;

endmodule

// File: doc/clk_step_ctrl.md
CLK_STEP_CTRL -- requirements
Module: clk_step_ctrl

Interface
REQ-001 Parameter DIV_W, default 8: width of the clock-divide ratio input.
REQ-002 Parameter CNT_W, default 32: width of the CPU cycle counter and breakpoint compare value.
REQ-003 Parameter RST_CYCLES, default 4: number of CPU enable ticks for which CPU reset is held after block reset.
REQ-004 Parameter START_HALTED, default 0: 1 = enter HALT after the reset sequence, 0 = enter RUN.
REQ-005 CLK  input  1  single system clock; all state on its rising edge.
REQ-006 RST_N  input  1  reset, asynchronous and active-low.
REQ-007 DIV  input  DIV_W  divide ratio; CPU enable tick every DIV+1 CLK cycles.
REQ-008 RUN_REQ  input  1  level-sampled request to leave HALT and free-run.
REQ-009 HALT_REQ  input  1  level-sampled request to stop issuing CPU enables.
REQ-010 STEP_REQ  input  1  request for exactly one CPU enable from HALT.
REQ-011 BRK_EN  input  1  breakpoint enable.
REQ-012 BRK_VAL  input  CNT_W  cycle count at which to halt.
REQ-013 CPU_EN  output  1  one-CLK-wide clock-enable pulse to the CPU pipeline.
REQ-014 CPU_RST_N  output  1  active-low CPU reset, asserted asynchronously, deasserted synchronously.
REQ-015 CYCLE_CNT  output  CNT_W  count of CPU_EN pulses issued outside reset hold.
REQ-016 HALTED  output  1  high while in HALT state.
REQ-017 STATE  output  2  encoding: 00 RST_HOLD, 01 RUN, 10 HALT, 11 STEP.

Function
REQ-018 Divider counter div_cnt (DIV_W bits) SHALL raise internal tick when div_cnt >= DIV and return to 0 that cycle, else increment; DIV=0 gives tick every CLK.
REQ-019 DIV change mid-count SHALL take effect immediately by the >= compare (no lockup when new DIV < div_cnt).
REQ-020 CPU_EN SHALL equal tick in RST_HOLD, RUN and STEP (subject to REQ-024, REQ-027); 0 in HALT.
REQ-021 RST_HOLD: CPU_RST_N=0; hold counter counts ticks; after the RST_CYCLES-th tick go to HALT if START_HALTED else RUN; CPU_RST_N=1 from the next cycle.
REQ-022 RST_CYCLES=0 SHALL behave as 1.
REQ-023 CYCLE_CNT SHALL increment on every CPU_EN in RUN or STEP, wrap modulo 2^CNT_W, never count in RST_HOLD.
REQ-024 RUN: HALT_REQ high -> HALT next cycle, and a tick coinciding with HALT_REQ SHALL be suppressed (CPU_EN=0, no count).
REQ-025 RUN breakpoint: if BRK_EN and a CPU_EN is issued with CYCLE_CNT+1 == BRK_VAL (mod 2^CNT_W), that pulse is issued and state goes to HALT next cycle.
REQ-026 HALT: RUN_REQ -> RUN; else STEP_REQ -> STEP; RUN_REQ wins when both high; HALT_REQ ignored.
REQ-027 STEP: wait for next tick, issue exactly one CPU_EN, return to HALT next cycle; HALT_REQ and RUN_REQ ignored while in STEP; breakpoint not evaluated.
REQ-028 A STEP_REQ held high SHALL yield one step per HALT->STEP round trip, not one per cycle within STEP.
REQ-029 Leaving HALT SHALL not reset div_cnt; first CPU_EN follows next natural tick.

Reset
REQ-030 RST_N low SHALL asynchronously force: state RST_HOLD, div_cnt 0, hold counter 0, CYCLE_CNT 0, CPU_EN 0, CPU_RST_N 0, HALTED 0, STATE 00.
REQ-031 RST_N low mid-RUN or mid-STEP SHALL abort immediately with no further CPU_EN until the full reset sequence reruns.

Verification
REQ-032 DIV=0, START_HALTED=0, RST_CYCLES=4, release RST_N -> CPU_EN high 4 CLK in RST_HOLD with CPU_RST_N=0, then CPU_RST_N=1, CPU_EN every CLK, CYCLE_CNT 1,2,3...
REQ-033 DIV=3 in RUN -> CPU_EN once per 4 CLK; change DIV to 1 when div_cnt=3 -> tick that cycle, then period 2.
REQ-034 BRK_EN=1, BRK_VAL=10, DIV=0 -> exactly 10 run pulses, HALTED=1, CYCLE_CNT=10, CPU_EN stays 0.
REQ-035 From HALT, pulse STEP_REQ 1 CLK three times with DIV=2 -> three single CPU_EN pulses, CYCLE_CNT +3, HALTED returns 1 after each.
REQ-036 HALT_REQ asserted on a tick cycle in RUN -> no CPU_EN that cycle, HALT next; RUN_REQ and STEP_REQ together -> RUN.
REQ-037 RST_N pulsed low mid-RUN at CYCLE_CNT=7 -> outputs immediately per REQ-030, CYCLE_CNT 0, reset sequence repeats.
